// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared constants, state encoding and sizing helper for bin2bcd_seq.
package bin2bcd_seq_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    // Smallest digit count that holds 2^bin_w-1 without overflow.
    function automatic int min_digits(input int bin_w);
        longint unsigned lim;
        longint unsigned p;
        int d;
        lim = (64'd1 << bin_w) - 64'd1;
        p = 64'd10;
        d = 1;
        while (p <= lim) begin
            d++;
            p *= 64'd10;
        end
        return d;
    endfunction
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done handshake and result bus of the converter.
//   master: drives start, bin; observes busy, done, bcd, blank, overflow.
//   slave : the converter side.
interface bin2bcd_seq_if #(parameter int BIN_W = 8, parameter int DIGITS = 3);
    import bin2bcd_seq_pkg::*;
    logic                          start;
    logic [BIN_W-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]             blank;
    logic                          overflow;
    modport master (output start, bin, input busy, done, bcd, blank, overflow);
    modport slave  (input start, bin, output busy, done, bcd, blank, overflow);
endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble cell, adds 3 to a BCD digit that is >= 5.
//   i_d: scratch digit in, o_d: adjusted digit out (4-bit, no carry out).
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);
    assign o_d = (i_d >= BCD_DIGIT_W'(5)) ? i_d + BCD_DIGIT_W'(3) : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock.
//   pclk : rising-edge clock
//   rst_n: asynchronous active-low reset
//   bus  : slave side of bin2bcd_seq_if (start/bin in; busy/done/bcd/blank/overflow out)
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          pclk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DW    = BCD_DIGIT_W * DIGITS;
    state_t             r_state;
    logic [BIN_W-1:0]   r_sr;
    logic [DW-1:0]      r_dig;
    logic [DW-1:0]      r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGITS-1:0]  r_blank;
    logic               r_ovf;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;
    logic [DW-1:0]      w_adj;
    logic [DW-1:0]      w_dig_next;
    logic [BIN_W-1:0]   w_sr_next;
    logic               w_out;
    logic [DIGITS-1:0]  w_blank;
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d (r_dig[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .o_d (w_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end
    // w_out is the bit shifted out of the top digit; any 1 there means lost magnitude.
    assign {w_out, w_dig_next, w_sr_next} = {w_adj, r_sr, 1'b0};
    // Walk down from the MSD while digits stay zero; digit 0 is never blanked.
    always_comb begin
        logic z;
        w_blank = '0;
        z = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z = z && (w_dig_next[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
            w_blank[k] = z;
        end
    end
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_dig      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= {DIGITS{1'b1}} << 1;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_sr    <= bus.bin;
                    r_dig   <= '0;
                    r_ovf   <= 1'b0;
                    r_cnt   <= CNT_W'(BIN_W);
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
            end else begin
                r_sr  <= w_sr_next;
                r_dig <= w_dig_next;
                r_ovf <= r_ovf | w_out;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_bcd      <= w_dig_next;
                    r_blank    <= w_blank;
                    r_overflow <= r_ovf | w_out;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            end
        end
    end
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.blank    = r_blank;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table, corner-sequence and random checks of bin2bcd_seq (8b/3 digits and 8b/2 digits).
module tb_bin2bcd_seq;
    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 pclk = ~pclk;
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b3 ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d3 (.pclk(pclk), .rst_n(rst_n), .bus(b3));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d2 (.pclk(pclk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int         v;
        logic [11:0] bcd;
        logic [2:0]  blank;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by plain arithmetic, truncated to d digits.
    function automatic logic [63:0] ref_bcd(input int v, input int d);
        logic [63:0] r = '0;
        int p = 1;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction
    function automatic logic [63:0] ref_blank(input int v, input int d);
        logic [63:0] r = '0;
        int p = 1;
        for (int k = 1; k < d; k++) begin
            p *= 10;
            r[k] = ((v % (p * pow10(d - k))) / p == 0) ? 1'b1 : 1'b0;
        end
        return r;
    endfunction
    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p *= 10;
        return p;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 3) ? b3.busy : b2.busy;
    endfunction

    task automatic start_conv(input int which, input int v);
        @(negedge pclk);
        if (which == 3) begin b3.start = 1'b1; b3.bin = 8'(v); end
        else begin b2.start = 1'b1; b2.bin = 8'(v); end
        @(negedge pclk);
        b3.start = 1'b0;
        b2.start = 1'b0;
    endtask

    // Counts busy cycles (the accept cycle included), then samples the done cycle and the cycle after.
    task automatic conv(input int which, input int v, output int cyc, output logic done,
                        output logic [11:0] bcd, output logic [2:0] blank, output logic ovf,
                        output logic done_after);
        start_conv(which, v);
        cyc = 0;
        while (busy_of(which) && cyc < 20) begin
            cyc++;
            @(negedge pclk);
        end
        done  = (which == 3) ? b3.done : b2.done;
        bcd   = (which == 3) ? b3.bcd : 12'(b2.bcd);
        blank = (which == 3) ? b3.blank : 3'(b2.blank);
        ovf   = (which == 3) ? b3.overflow : b2.overflow;
        @(negedge pclk);
        done_after = (which == 3) ? b3.done : b2.done;
    endtask

    task automatic conv_ref(input int which, input int v, input string tag);
        int cyc;
        logic done, ovf, done_after;
        logic [11:0] bcd;
        logic [2:0] blank;
        conv(which, v, cyc, done, bcd, blank, ovf, done_after);
        chk({tag, ".cycles"}, 64'(cyc), 64'd8);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".bcd"}, 64'(bcd), ref_bcd(v, which));
        chk({tag, ".blank"}, 64'(blank), ref_blank(v, which));
        chk({tag, ".ovf"}, 64'(ovf), 64'(v >= pow10(which)));
        chk({tag, ".done_clr"}, 64'(done_after), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, held_bad, dones;
        logic done, ovf, done_after;
        logic [11:0] bcd;
        logic [2:0] blank;
        tbl[0] = '{255, 12'h255, 3'b000};
        tbl[1] = '{0,   12'h000, 3'b110};
        tbl[2] = '{7,   12'h007, 3'b110};
        tbl[3] = '{42,  12'h042, 3'b100};
        tbl[4] = '{100, 12'h100, 3'b000};
        tbl[5] = '{10,  12'h010, 3'b100};
        tbl[6] = '{1,   12'h001, 3'b110};
        tbl[7] = '{128, 12'h128, 3'b000};
        b3.start = 1'b0; b3.bin = '0;
        b2.start = 1'b0; b2.bin = '0;
        #23;
        chk("rst.busy", 64'(b3.busy), 64'd0);
        chk("rst.done", 64'(b3.done), 64'd0);
        chk("rst.bcd", 64'(b3.bcd), 64'd0);
        chk("rst.blank", 64'(b3.blank), 64'b110);
        chk("rst.blank2", 64'(b2.blank), 64'b10);
        chk("rst.ovf", 64'(b3.overflow), 64'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            conv(3, tbl[i].v, cyc, done, bcd, blank, ovf, done_after);
            chk($sformatf("tbl%0d.cycles", i), 64'(cyc), 64'd8);
            chk($sformatf("tbl%0d.done", i), 64'(done), 64'd1);
            chk($sformatf("tbl%0d.bcd", i), 64'(bcd), 64'(tbl[i].bcd));
            chk($sformatf("tbl%0d.blank", i), 64'(blank), 64'(tbl[i].blank));
            chk($sformatf("tbl%0d.ovf", i), 64'(ovf), 64'd0);
            chk($sformatf("tbl%0d.done_clr", i), 64'(done_after), 64'd0);
        end
        // start while busy is ignored
        start_conv(3, 200);
        repeat (2) @(negedge pclk);
        b3.start = 1'b1; b3.bin = 8'd9;
        @(negedge pclk);
        b3.start = 1'b0;
        cyc = 0;
        while (b3.busy && cyc < 20) begin cyc++; @(negedge pclk); end
        chk("busy_start.done", 64'(b3.done), 64'd1);
        chk("busy_start.bcd", 64'(b3.bcd), 64'h200);
        dones = 0;
        repeat (12) begin @(negedge pclk); dones += int'(b3.done); end
        chk("busy_start.no_second_done", 64'(dones), 64'd0);
        // bin changes after acceptance have no effect
        start_conv(3, 50);
        b3.bin = 8'd77;
        cyc = 1;
        while (b3.busy && cyc < 20) begin cyc++; @(negedge pclk); end
        chk("bin_late.bcd", 64'(b3.bcd), 64'h050);
        // back-to-back: new start in the done cycle
        start_conv(3, 99);
        cyc = 0;
        while (b3.busy && cyc < 20) begin cyc++; @(negedge pclk); end
        chk("b2b.first_done", 64'(b3.done), 64'd1);
        chk("b2b.first_bcd", 64'(b3.bcd), 64'h099);
        b3.start = 1'b1; b3.bin = 8'd100;
        @(negedge pclk);
        b3.start = 1'b0;
        chk("b2b.busy", 64'(b3.busy), 64'd1);
        chk("b2b.done_clr", 64'(b3.done), 64'd0);
        cyc = 0;
        held_bad = 0;
        while (b3.busy && cyc < 20) begin
            if (b3.bcd !== 12'h099 || b3.done !== 1'b0) held_bad++;
            cyc++;
            @(negedge pclk);
        end
        chk("b2b.held", 64'(held_bad), 64'd0);
        chk("b2b.cycles", 64'(cyc), 64'd8);
        chk("b2b.second_done", 64'(b3.done), 64'd1);
        chk("b2b.second_bcd", 64'(b3.bcd), 64'h100);
        // reset in the middle of a conversion
        start_conv(3, 255);
        repeat (3) @(negedge pclk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 64'(b3.busy), 64'd0);
        chk("midrst.bcd", 64'(b3.bcd), 64'd0);
        chk("midrst.blank", 64'(b3.blank), 64'b110);
        chk("midrst.done", 64'(b3.done), 64'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin @(negedge pclk); dones += int'(b3.done); end
        chk("midrst.no_done", 64'(dones), 64'd0);
        conv_ref(3, 1, "after_rst");
        // two-digit instance: truncation and overflow
        conv_ref(2, 255, "d2_255");
        conv_ref(2, 99, "d2_99");
        conv_ref(2, 100, "d2_100");
        for (int i = 0; i < 25; i++) conv_ref(3, int'($urandom_range(0, 255)), $sformatf("rnd3_%0d", i));
        for (int i = 0; i < 15; i++) conv_ref(2, int'($urandom_range(0, 255)), $sformatf("rnd2_%0d", i));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
